// File: rtl/macro_wb_pkg.sv
// ============================================================================
// Module   : macro_wb_pkg
// Brief    : Shared constants for the macro Wishbone sequencer: default macro
//            count, address tag, error data word and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package macro_wb_pkg;

    // Default number of user macros behind the sequencer
    localparam int N_MACRO_DEF = 11;

    // Address tag in wbs_adr_i[31:28] that selects the macro window
    localparam logic [3:0] ADR_TAG = 4'h3;

    // Data returned for a bad macro index or an expired request
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Sequencer FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage : macro_wb_pkg

`default_nettype wire

// File: rtl/macro_wb_timeout.sv
// ============================================================================
// Module   : macro_wb_timeout
// Brief    : 8-bit request watchdog. Cleared when a request is launched,
//            counts every cycle the request is outstanding, and flags expiry
//            on the cycle whose count would reach TIMEOUT_CYC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module macro_wb_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear on launch, advance while the request is outstanding
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires on the edge that would bring the count to TIMEOUT_CYC,
    // so the strobe stays up for exactly TIMEOUT_CYC cycles.
    assign expired_o = en_i && (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule : macro_wb_timeout

`default_nettype wire

// File: rtl/macro_wb_sequencer.sv
// ============================================================================
// Module   : macro_wb_sequencer
// Brief    : Routes single host Wishbone reads to one of N_MACRO user macros
//            selected by wbs_adr_i[27:24] (when tag wbs_adr_i[31:28] == 3),
//            waits for that macro's ack and returns its data with a
//            registered one-cycle host ack. Bad indices return ERR_DATA.
//            Optional request watchdog enabled by `define MACRO_WB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module macro_wb_sequencer
    import macro_wb_pkg::*;
#(
    parameter int N_MACRO     = N_MACRO_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [N_MACRO-1:0]     m_wbs_stb_o,
    input  logic [N_MACRO-1:0]     m_wbs_ack_i,
    input  logic [32*N_MACRO-1:0]  m_wbs_dat_i,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic [3:0]             last_sel_o
);

    logic [1:0]          state_q, state_d;
    logic [3:0]          sel_q,   sel_d;
    logic [N_MACRO-1:0]  stb_q,   stb_d;
    logic                ack_q,   ack_d;
    logic [31:0]         dat_q,   dat_d;
    logic                busy_q,  busy_d;

    logic [3:0]          w_tag;
    logic [3:0]          w_idx;
    logic                w_idx_ok;
    logic                w_host_req;
    logic [N_MACRO-1:0]  w_onehot;
    logic                w_ack_sel;
    logic [31:0]         w_dat_sel;
    logic                w_launch;
    logic                w_adr_unused;

    assign w_tag        = wbs_adr_i[31:28];
    assign w_idx        = wbs_adr_i[27:24];
    assign w_idx_ok     = int'(w_idx) < N_MACRO;
    assign w_host_req   = wbs_cyc_i && wbs_stb_i && (w_tag == ADR_TAG);
    assign w_onehot     = N_MACRO'(1) << w_idx;
    assign w_launch     = (state_q == ST_IDLE) && w_host_req && w_idx_ok;
    assign w_adr_unused = ^wbs_adr_i[23:0];

    // Pick the ack and data lane of the currently selected macro only
    always_comb begin
        w_ack_sel = 1'b0;
        w_dat_sel = 32'd0;
        for (int k = 0; k < N_MACRO; k++) begin
            if (sel_q == 4'(k)) begin
                w_ack_sel = m_wbs_ack_i[k];
                w_dat_sel = m_wbs_dat_i[32*k +: 32];
            end
        end
    end

`ifdef MACRO_WB_TIMEOUT_EN
    logic w_expired;
    logic tmo_q, tmo_d;

    macro_wb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .clr_i     (w_launch),
        .en_i      (state_q == ST_REQ),
        .expired_o (w_expired)
    );
`else
    logic [7:0] w_tmo_cfg_unused;
    assign w_tmo_cfg_unused = 8'(TIMEOUT_CYC);
`endif

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        ack_d   = 1'b0;
        dat_d   = 32'd0;
`ifdef MACRO_WB_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_host_req) begin
                    if (w_idx_ok) begin
                        sel_d   = w_idx;
                        stb_d   = w_onehot;
                        state_d = ST_REQ;
                    end else begin
                        // Ack is raised from RESP one cycle later so a bad
                        // index sees the same latency as a fast macro.
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (!wbs_cyc_i) begin
                    // Host abandoned the cycle: drop quietly, no ack
                    stb_d   = '0;
                    state_d = ST_IDLE;
                end else if (w_ack_sel) begin
                    // A real ack wins over a same-cycle watchdog expiry
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    dat_d   = w_dat_sel;
                    state_d = ST_RESP;
`ifdef MACRO_WB_TIMEOUT_EN
                end else if (w_expired) begin
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    dat_d   = ERR_DATA;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
`endif
                end
            end
            ST_RESP: begin
                if (!ack_q) begin
                    // Pending error response: present it now
                    ack_d = 1'b1;
                    dat_d = ERR_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                stb_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            sel_q   <= 4'd0;
            stb_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
        end
    end

`ifdef MACRO_WB_TIMEOUT_EN
    // Watchdog pulse register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign m_wbs_stb_o = stb_q;
    assign busy_o      = busy_q;
    assign last_sel_o  = sel_q;

endmodule : macro_wb_sequencer

`default_nettype wire

// File: tb/tb_macro_wb_sequencer.sv
// ============================================================================
// Module   : tb_macro_wb_sequencer
// Brief    : Directed self-checking bench for macro_wb_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_macro_wb_sequencer;

    localparam int          NM  = 11;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              cyc    = 1'b0;
    logic              stb    = 1'b0;
    logic [31:0]       adr    = 32'd0;
    logic              ack;
    logic [31:0]       dat;
    logic [NM-1:0]     mstb;
    logic [NM-1:0]     mack;
    logic [32*NM-1:0]  mdat_bus;
    logic              busy;
    logic              tmo;
    logic [3:0]        lsel;

    logic [NM-1:0]     comb_en = '0;
    logic [NM-1:0]     man_ack = '0;
    logic [31:0]       mdat [NM];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Macro model: a macro acks while strobed if enabled, plus forced acks
    assign mack = (mstb & comb_en) | man_ack;

    always_comb begin
        for (int k = 0; k < NM; k++) mdat_bus[32*k +: 32] = mdat[k];
    end

    macro_wb_sequencer #(
        .N_MACRO     (NM),
        .TIMEOUT_CYC (4)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat),
        .m_wbs_stb_o (mstb),
        .m_wbs_ack_i (mack),
        .m_wbs_dat_i (mdat_bus),
        .busy_o      (busy),
        .timeout_o   (tmo),
        .last_sel_o  (lsel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // At most one macro strobe in any cycle
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            assert ($countones(mstb) <= 1) else begin
                fails++;
                $error("FAIL onehot: observed %h expected at most one bit", mstb);
            end
        end
    end

    initial begin : main
        logic [3:0]    idx;
        logic [NM-1:0] oh;
        logic [31:0]   val;
        logic [31:0]   exp;
        logic [31:0]   got;
        int            d;
        int            nack;

        for (int k = 0; k < NM; k++) mdat[k] = 32'h0;

        // ---- reset state
        #2;
        chk("rst_ack",  32'(ack),  32'd0);
        chk("rst_dat",  dat,       32'd0);
        chk("rst_mstb", 32'(mstb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo",  32'(tmo),  32'd0);
        chk("rst_lsel", 32'(lsel), 32'd0);
        #10 rst_n = 1'b1;
        step();

        // ---- macro 2, combinational ack
        mdat[2] = 32'h1234_5678;
        comb_en = 11'h004;
        adr = 32'h3200_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("s1_mstb", 32'(mstb), 32'h004);
        chk("s1_lsel", 32'(lsel), 32'd2);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_ack0", 32'(ack),  32'd0);
        step();
        chk("s1_ack",  32'(ack),  32'd1);
        chk("s1_dat",  dat,       32'h1234_5678);
        chk("s1_mstb_off", 32'(mstb), 32'd0);
        cyc = 1'b0; stb = 1'b0; comb_en = '0;
        step();
        chk("s1_ack_end", 32'(ack),  32'd0);
        chk("s1_dat_end", dat,       32'd0);
        chk("s1_idle",    32'(busy), 32'd0);

        // ---- bad index 11
        adr = 32'h3B00_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("s2_mstb", 32'(mstb), 32'd0);
        chk("s2_ack0", 32'(ack),  32'd0);
        chk("s2_busy", 32'(busy), 32'd1);
        step();
        chk("s2_ack",  32'(ack),  32'd1);
        chk("s2_dat",  dat,       ERR);
        chk("s2_lsel", 32'(lsel), 32'd2);
        cyc = 1'b0; stb = 1'b0;
        step();
        chk("s2_ack_end", 32'(ack),  32'd0);
        chk("s2_idle",    32'(busy), 32'd0);

        // ---- wrong tag ignored
        adr = 32'h0200_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("tag_busy", 32'(busy), 32'd0);
        chk("tag_mstb", 32'(mstb), 32'd0);
        step();
        chk("tag_ack",  32'(ack),  32'd0);
        cyc = 1'b0; stb = 1'b0;

        // ---- macro 5 strobed, macro 4 acks first, macro 5 acks 3 cycles later
        mdat[4] = 32'h1111_1111;
        mdat[5] = 32'hA5A5_A5A5;
        adr = 32'h3500_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("s3_mstb", 32'(mstb), 32'h020);
        man_ack = 11'h010;
        step();
        chk("s3_ign_ack",  32'(ack),  32'd0);
        chk("s3_ign_mstb", 32'(mstb), 32'h020);
        man_ack = '0;
        step();
        step();
        man_ack = 11'h020;
        step();
        chk("s3_ack",  32'(ack),  32'd1);
        chk("s3_dat",  dat,       32'hA5A5_A5A5);
        chk("s3_mstb_off", 32'(mstb), 32'd0);
        chk("s3_tmo",  32'(tmo),  32'd0);
        man_ack = '0; cyc = 1'b0; stb = 1'b0;
        step();
        chk("s3_ack_end", 32'(ack), 32'd0);

        // ---- host drops cyc during REQ; late ack ignored
        adr = 32'h3100_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("ab_mstb", 32'(mstb), 32'h002);
        cyc = 1'b0; stb = 1'b0; man_ack = 11'h002;
        step();
        chk("ab_mstb_off", 32'(mstb), 32'd0);
        chk("ab_busy",     32'(busy), 32'd0);
        chk("ab_ack",      32'(ack),  32'd0);
        step();
        chk("ab_late_ack", 32'(ack),  32'd0);
        man_ack = '0;

        // ---- reset pulse during REQ
        adr = 32'h3700_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("rr_mstb", 32'(mstb), 32'h080);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_mstb_off", 32'(mstb), 32'd0);
        chk("rr_busy",     32'(busy), 32'd0);
        chk("rr_lsel",     32'(lsel), 32'd0);
        cyc = 1'b0; stb = 1'b0; man_ack = 11'h080;
        #3 rst_n = 1'b1;
        step();
        chk("rr_ack1", 32'(ack),  32'd0);
        chk("rr_busy1", 32'(busy), 32'd0);
        step();
        chk("rr_ack2", 32'(ack),  32'd0);
        man_ack = '0;

        // ---- normal transaction afterwards, macro 10
        mdat[10] = 32'h0A0A_0A0A;
        comb_en = 11'h400;
        adr = 32'h3A00_0000; cyc = 1'b1; stb = 1'b1;
        step();
        chk("s4_mstb", 32'(mstb), 32'h400);
        chk("s4_lsel", 32'(lsel), 32'd10);
        step();
        chk("s4_ack",  32'(ack),  32'd1);
        chk("s4_dat",  dat,       32'h0A0A_0A0A);
        cyc = 1'b0; stb = 1'b0; comb_en = '0;
        step();
        chk("s4_ack_end", 32'(ack), 32'd0);

`ifdef MACRO_WB_TIMEOUT_EN
        // ---- macro 0 never acks: watchdog after 4 REQ cycles
        adr = 32'h3000_0000; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_mstb", 32'(mstb), 32'h001);
            chk("to_tmo0", 32'(tmo),  32'd0);
        end
        step();
        chk("to_mstb_off", 32'(mstb), 32'd0);
        chk("to_tmo",      32'(tmo),  32'd1);
        chk("to_ack",      32'(ack),  32'd1);
        chk("to_dat",      dat,       ERR);
        cyc = 1'b0; stb = 1'b0;
        step();
        chk("to_tmo_end", 32'(tmo), 32'd0);
        chk("to_ack_end", 32'(ack), 32'd0);
`endif

        // ---- 100 back-to-back transactions
        cyc = 1'b1; stb = 1'b1;
        for (int t = 0; t < 100; t++) begin
            idx = 4'($urandom_range(0, 12));
            d   = int'($urandom_range(0, 2));
            val = $urandom;
            oh  = '0;
            exp = ERR;
            if (int'(idx) < NM) begin
                mdat[idx] = val;
                oh  = NM'(1) << idx;
                exp = val;
            end
            comb_en = '0;
            man_ack = NM'($urandom) & ~oh;
            adr     = {4'h3, idx, 24'($urandom)};
            nack    = 0;
            got     = 32'd0;
            for (int c = 0; c < 12; c++) begin
                if (c == d) comb_en = oh;
                step();
                if (ack) begin
                    nack++;
                    got = dat;
                    break;
                end
            end
            man_ack = '0;
            comb_en = '0;
            if (t == 99) begin
                cyc = 1'b0; stb = 1'b0;
            end
            step();
            if (ack) nack++;
            chk("b2b_nack", 32'(nack), 32'd1);
            chk("b2b_dat",  got,       exp);
        end
        step();
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_macro_wb_sequencer

`default_nettype wire
